// File: rtl/hicore_itcm_icb_slave.sv
// ICB responder for instruction fetch backed by a one-cycle-latency single-port ITCM SRAM.
// Define HICORE_ITCM_WRITE_EN to allow writes; otherwise the ITCM is read-only and writes error.
module hicore_itcm_icb_slave #(
    parameter int unsigned    AW        = 32,
    parameter int unsigned    DW        = 32,
    parameter int unsigned    RAM_AW    = 14,
    parameter logic [AW-1:0]  ITCM_BASE = 32'h8000_0000,
    parameter int unsigned    OUTS_DP   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icb_cmd_valid_i,
    output logic              icb_cmd_ready_o,
    input  logic              icb_cmd_read_i,
    input  logic [AW-1:0]     icb_cmd_addr_i,
    input  logic [DW-1:0]     icb_cmd_wdata_i,
    input  logic [DW/8-1:0]   icb_cmd_wmask_i,
    output logic              icb_rsp_valid_o,
    input  logic              icb_rsp_ready_i,
    output logic [DW-1:0]     icb_rsp_rdata_o,
    output logic              icb_rsp_err_o,
    output logic              ram_cs_o,
    output logic              ram_we_o,
    output logic [DW/8-1:0]   ram_wem_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [DW-1:0]     ram_din_o,
    input  logic [DW-1:0]     ram_dout_i
);

    // One slot per credit: an S1 entry that is not consumed always has room to drain into.
    localparam int unsigned FifoDp = OUTS_DP;
    localparam int unsigned PtrW   = (FifoDp > 1) ? $clog2(FifoDp) : 1;
    localparam int unsigned CntW   = $clog2(FifoDp + 1);

    logic            cmd_hsk;
    logic            in_range;
    logic            misalign;
    logic            wr_bad;
    logic            bad;

    logic            s1_vld_q;
    logic            s1_err_q;
    logic            s1_rd_q;
    logic [DW-1:0]   s1_rdata;

    logic [DW:0]     fifo_mem_q [FifoDp];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] fifo_cnt_q;
    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic            pop;
    logic [CntW:0]   inflight;
    logic [DW:0]     rsp_ent;

    assign inflight        = {1'b0, fifo_cnt_q} + {{CntW{1'b0}}, s1_vld_q};
    assign icb_cmd_ready_o = (inflight < (CntW + 1)'(OUTS_DP));
    assign cmd_hsk         = icb_cmd_valid_i & icb_cmd_ready_o;

    assign in_range = (icb_cmd_addr_i[AW-1:RAM_AW+2] == ITCM_BASE[AW-1:RAM_AW+2]);
    assign misalign = |icb_cmd_addr_i[1:0];

`ifdef HICORE_ITCM_WRITE_EN
    assign wr_bad    = 1'b0;
    assign ram_we_o  = ram_cs_o & ~icb_cmd_read_i;
    assign ram_wem_o = ram_we_o ? icb_cmd_wmask_i : '0;
    assign ram_din_o = icb_cmd_wdata_i;
`else
    logic unused_wr;
    assign wr_bad    = ~icb_cmd_read_i;
    assign ram_we_o  = 1'b0;
    assign ram_wem_o = '0;
    assign ram_din_o = '0;
    assign unused_wr = ^{icb_cmd_wdata_i, icb_cmd_wmask_i};
`endif

    assign bad        = ~in_range | misalign | wr_bad;
    assign ram_cs_o   = cmd_hsk & ~bad;
    assign ram_addr_o = icb_cmd_addr_i[RAM_AW+1:2];

    // SRAM output is only valid in the S1 cycle, so S1 is either bypassed out or captured.
    assign s1_rdata   = (s1_rd_q & ~s1_err_q) ? ram_dout_i : '0;
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == CntW'(FifoDp));
    assign pop        = ~fifo_empty & icb_rsp_ready_i;
    assign push       = s1_vld_q & ~(fifo_empty & icb_rsp_ready_i);

    assign icb_rsp_valid_o = ~fifo_empty | s1_vld_q;
    assign rsp_ent         = fifo_empty ? {s1_rdata, s1_err_q} : fifo_mem_q[rptr_q];
    assign icb_rsp_rdata_o = rsp_ent[DW:1];
    assign icb_rsp_err_o   = rsp_ent[0];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDp - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_rd_q    <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            fifo_cnt_q <= '0;
        end else begin
            s1_vld_q <= cmd_hsk;
            if (cmd_hsk) begin
                s1_err_q <= bad;
                s1_rd_q  <= icb_cmd_read_i;
            end
            if (push) begin
                wptr_q <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + 1'b1;
            end else if (pop && !push) begin
                fifo_cnt_q <= fifo_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wptr_q] <= {s1_rdata, s1_err_q};
        end
    end

`ifndef SYNTHESIS
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && fifo_full));
`endif

endmodule

// File: tb/tb_hicore_itcm_icb_slave.sv
// Randomized self-checking bench for hicore_itcm_icb_slave with an in-order response model.
module tb_hicore_itcm_icb_slave;

    localparam int unsigned OutsDp = 2;
`ifdef HICORE_ITCM_WRITE_EN
    localparam bit WrEn = 1'b1;
`else
    localparam bit WrEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_read;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        ram_cs, ram_we;
    logic [3:0]  ram_wem;
    logic [13:0] ram_addr;
    logic [31:0] ram_din, ram_dout;

    hicore_itcm_icb_slave #(.OUTS_DP(OutsDp)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .icb_cmd_valid_i (cmd_valid),
        .icb_cmd_ready_o (cmd_ready),
        .icb_cmd_read_i  (cmd_read),
        .icb_cmd_addr_i  (cmd_addr),
        .icb_cmd_wdata_i (cmd_wdata),
        .icb_cmd_wmask_i (cmd_wmask),
        .icb_rsp_valid_o (rsp_valid),
        .icb_rsp_ready_i (rsp_ready),
        .icb_rsp_rdata_o (rsp_rdata),
        .icb_rsp_err_o   (rsp_err),
        .ram_cs_o        (ram_cs),
        .ram_we_o        (ram_we),
        .ram_wem_o       (ram_wem),
        .ram_addr_o      (ram_addr),
        .ram_din_o       (ram_din),
        .ram_dout_i      (ram_dout)
    );

    always #5 clk = ~clk;

    logic [31:0] sram    [16384];
    logic [31:0] ref_mem [16384];

    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_wem[b]) sram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
                end
            end else begin
                ram_dout <= sram[ram_addr];
            end
        end
    end

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [32:0] exp_q [$];
    logic        hold_pend = 1'b0;
    logic [32:0] held;
    logic [31:0] last_rdata;
    logic        last_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, then check handshakes, ordering and SRAM control against the model.
    task automatic do_cycle(input logic v, input logic rd, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] wm, input logic rr,
                            output logic acc);
        logic        bad;
        logic [32:0] e;
        logic [31:0] w;
        @(negedge clk);
        cmd_valid = v; cmd_read = rd; cmd_addr = a; cmd_wdata = wd; cmd_wmask = wm;
        rsp_ready = rr;
        #1;
        check("cmd_ready", cmd_ready, exp_q.size() < OutsDp);
        check("rsp_valid", rsp_valid, exp_q.size() > 0);
        if (hold_pend) check("rsp_hold", {rsp_rdata, rsp_err}, held);
        acc = v & cmd_ready;
        if (rsp_valid && rr && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rsp_data", {rsp_rdata, rsp_err}, e);
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
        end
        hold_pend = rsp_valid & ~rr;
        held      = {rsp_rdata, rsp_err};
        if (acc) begin
            bad = (a[31:16] != 16'h8000) || (a[1:0] != 2'b00) || (!rd && !WrEn);
            check("ram_cs", ram_cs, !bad);
            if (!bad) begin
                check("ram_addr", ram_addr, a[15:2]);
                check("ram_we", ram_we, !rd);
                if (!rd) check("ram_wem", ram_wem, wm);
            end
            if (bad) begin
                exp_q.push_back({32'h0, 1'b1});
            end else if (rd) begin
                exp_q.push_back({ref_mem[a[15:2]], 1'b0});
            end else begin
                w = ref_mem[a[15:2]];
                for (int b = 0; b < 4; b++) if (wm[b]) w[8*b +: 8] = wd[8*b +: 8];
                ref_mem[a[15:2]] = w;
                exp_q.push_back({32'h0, 1'b0});
            end
        end else begin
            check("ram_cs_idle", ram_cs, 1'b0);
        end
    endtask

    task automatic issue(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] wm);
        logic acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) do_cycle(1'b1, rd, a, wd, wm, 1'b1, acc);
        check("issue_acc", acc, 1'b1);
    endtask

    task automatic drain();
        logic acc;
        for (int k = 0; k < 50 && exp_q.size() > 0; k++)
            do_cycle(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b1, acc);
        check("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        logic        acc;
        logic [31:0] a;
        logic        rd;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b1; cmd_addr = '0;
        cmd_wdata = '0; cmd_wmask = '0; rsp_ready = 1'b0; ram_dout = '0;
        for (int i = 0; i < 16384; i++) begin
            sram[i] = $urandom; ref_mem[i] = sram[i];
        end
        sram[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
        sram[8] = 32'hAAAA_BBBB; ref_mem[8] = 32'hAAAA_BBBB;
        #12;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_ram_cs", ram_cs, 1'b0);
        check("rst_ram_we", ram_we, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        // Single read of word 4.
        do_cycle(1'b1, 1'b1, 32'h8000_0010, 32'h0, 4'h0, 1'b1, acc);
        check("t1_acc", acc, 1'b1);
        do_cycle(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b1, acc);
        check("t1_rdata", {last_rdata, last_err}, {32'hDEAD_BEEF, 1'b0});

        // Back-to-back reads at full rate.
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b1, 1'b1, 32'h8000_0000 + 32'(4 * i), 32'h0, 4'h0, 1'b1, acc);
            check("t2_acc", acc, 1'b1);
        end
        drain();

        // Back-pressure: two accepted, third blocked, then drain in order.
        do_cycle(1'b1, 1'b1, 32'h8000_0010, 32'h0, 4'h0, 1'b0, acc);
        check("t3_acc0", acc, 1'b1);
        do_cycle(1'b1, 1'b1, 32'h8000_0020, 32'h0, 4'h0, 1'b0, acc);
        check("t3_acc1", acc, 1'b1);
        do_cycle(1'b1, 1'b1, 32'h8000_0030, 32'h0, 4'h0, 1'b0, acc);
        check("t3_blocked", acc, 1'b0);
        do_cycle(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0, acc);
        drain();

        // Error responses interleaved with good reads.
        issue(1'b1, 32'h8000_0000, 32'h0, 4'h0);
        issue(1'b1, 32'h8000_0002, 32'h0, 4'h0);
        issue(1'b1, 32'h0000_1000, 32'h0, 4'h0);
        issue(1'b1, 32'h8000_0004, 32'h0, 4'h0);
        drain();

        // Partial write then readback.
        issue(1'b0, 32'h8000_0020, 32'h1234_5678, 4'b0011);
        drain();
        check("t5_wr_err", last_err, !WrEn);
        issue(1'b1, 32'h8000_0020, 32'h0, 4'h0);
        drain();
        check("t5_readback", last_rdata, WrEn ? 32'hAAAA_5678 : 32'hAAAA_BBBB);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'h8000_0000 + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
                1:       a = 32'($urandom_range(0, 32'h7FFF_FFFF));
                default: a = 32'h8000_0000 + 32'($urandom_range(0, 63)) * 4;
            endcase
            rd = ($urandom_range(0, 3) != 0);
            do_cycle($urandom_range(0, 9) < 7, rd, a, $urandom, 4'($urandom),
                     $urandom_range(0, 9) < 6, acc);
        end
        drain();

        // Reset with two responses in flight.
        do_cycle(1'b1, 1'b1, 32'h8000_0010, 32'h0, 4'h0, 1'b0, acc);
        do_cycle(1'b1, 1'b1, 32'h8000_0014, 32'h0, 4'h0, 1'b0, acc);
        cmd_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check("mid_rst_cmd_ready", cmd_ready, 1'b1);
        exp_q.delete();
        hold_pend = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b1, acc);
        issue(1'b1, 32'h8000_0010, 32'h0, 4'h0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
